// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS MEM stage: datapath widths and the
// data-memory access FSM encoding.
package mips_pkg;

  localparam int DW          = 32;
  localparam int AW          = 32;
  localparam int RW          = 5;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_stage_ctrl_wb.sv
// MEM/WB pipeline register bank: loads a bubble while the stage stalls,
// otherwise captures the MEM-stage instruction (write enable killed on abort).
module mem_wb_reg #(
  parameter int DW = mips_pkg::DW,
  parameter int RW = mips_pkg::RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_bubble,
  input  logic          i_squash,
  input  logic          i_load_ack,
  input  logic          i_reg_write,
  input  logic          i_mem_to_reg,
  input  logic [DW-1:0] i_alu_res,
  input  logic [DW-1:0] i_rdata,
  input  logic [RW-1:0] i_wreg,
  output logic          o_reg_write,
  output logic          o_mem_to_reg,
  output logic [DW-1:0] o_rdata,
  output logic [DW-1:0] o_alu_res,
  output logic [RW-1:0] o_wreg
);

  logic          r_reg_write;
  logic          r_mem_to_reg;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_alu_res;
  logic [RW-1:0] r_wreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_rdata      <= '0;
      r_alu_res    <= '0;
      r_wreg       <= '0;
    end else if (i_bubble) begin
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_rdata      <= '0;
      r_alu_res    <= '0;
      r_wreg       <= '0;
    end else begin
      r_reg_write  <= i_reg_write & ~i_squash;
      r_mem_to_reg <= i_mem_to_reg;
      r_rdata      <= i_load_ack ? i_rdata : '0;
      r_alu_res    <= i_alu_res;
      r_wreg       <= i_wreg;
    end
  end

  assign o_reg_write  = r_reg_write;
  assign o_mem_to_reg = r_mem_to_reg;
  assign o_rdata      = r_rdata;
  assign o_alu_res    = r_alu_res;
  assign o_wreg       = r_wreg;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage of the 5-stage MIPS pipeline: issues loads/stores over a req/ack
// handshake, stalls upstream while an access is outstanding, resolves branches.
module mem_stage_ctrl
  import mips_pkg::*;
#(
  parameter int DW      = mips_pkg::DW,
  parameter int AW      = mips_pkg::AW,
  parameter int RW      = mips_pkg::RW,
  parameter int TIMEOUT = mips_pkg::TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          MEM_RegWrite,
  input  logic          MEM_Branch,
  input  logic          MEM_MemRead,
  input  logic          MEM_MemWrite,
  input  logic [31:0]   MEM_pc_br,
  input  logic          MEM_zero,
  input  logic [DW-1:0] MEM_ALU_res,
  input  logic [DW-1:0] MEM_rdata2,
  input  logic [RW-1:0] MEM_wreg,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic          stall,
  output logic          pc_src,
  output logic [31:0]   pc_br_out,
  output logic          WB_RegWrite,
  output logic          WB_MemtoReg,
  output logic [DW-1:0] WB_rdata,
  output logic [DW-1:0] WB_ALU_res,
  output logic [RW-1:0] WB_wreg,
  output logic          err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  // Handshake: dmem_req rises the cycle after a load/store enters MEM and holds,
  // with we/addr/wdata stable, until the first cycle dmem_ack=1 (rdata valid in
  // that same cycle) or until the timeout abort; acks outside ACCESS are ignored.
  mem_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_req;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_err;

  logic w_acc;
  logic w_in_access;
  logic w_done_ack;
  logic w_timeout;
  logic w_stall;
  logic w_is_load;

  assign w_acc       = MEM_MemRead | MEM_MemWrite;
  assign w_is_load   = MEM_MemRead & ~MEM_MemWrite;
  assign w_in_access = (r_state == ST_ACCESS);
  assign w_done_ack  = w_in_access & dmem_ack;
  assign w_timeout   = w_in_access & ~dmem_ack & (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE:   w_stall = w_acc;
      ST_ACCESS: w_stall = ~dmem_ack & ~w_timeout;
      default:   w_stall = 1'b0;
    endcase
  end

  // Gating with rst_n keeps stall low while reset is held, even with a load presented.
  assign stall     = w_stall & rst_n;
  assign pc_src    = MEM_Branch & MEM_zero & ~stall;
  assign pc_br_out = MEM_pc_br;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_state <= ST_ACCESS;
            r_cnt   <= '0;
            r_req   <= 1'b1;
            r_we    <= MEM_MemWrite;
            r_addr  <= AW'(MEM_ALU_res);
            r_wdata <= MEM_rdata2;
          end
        end
        ST_ACCESS: begin
          if (dmem_ack) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign err        = r_err;

  mem_wb_reg #(
    .DW (DW),
    .RW (RW)
  ) u_mem_wb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_bubble     (w_stall),
    .i_squash     (w_timeout),
    .i_load_ack   (w_done_ack & w_is_load),
    .i_reg_write  (MEM_RegWrite),
    .i_mem_to_reg (w_is_load),
    .i_alu_res    (MEM_ALU_res),
    .i_rdata      (dmem_rdata),
    .i_wreg       (MEM_wreg),
    .o_reg_write  (WB_RegWrite),
    .o_mem_to_reg (WB_MemtoReg),
    .o_rdata      (WB_rdata),
    .o_alu_res    (WB_ALU_res),
    .o_wreg       (WB_wreg)
  );

endmodule
